// File: rtl/packer_pkg.sv
// Shared constants and FSM encoding for the 1-bit FIFO word packer.
package packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/packer_shift_reg.sv
// LSB-first indexed bit loader: writes bit_in at the current index and advances it.
// `word` reflects the register including the bit being loaded this cycle.
module packer_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             last_bit
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign last_bit = (idx_q == IDX_W'(WIDTH - 1));

  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    if (clear) begin
      sreg_d = '0;
      idx_d  = '0;
    end else if (load) begin
      sreg_d[idx_q] = bit_in;
      idx_d         = last_bit ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Top captures this on the final pop, so it must already hold the incoming bit.
  assign word = sreg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/fifo_bit_packer.sv
// Pops bits from a 1-bit FIFO, packs WIDTH of them LSB-first, presents the word on valid/ready.
// Optional WORD_PAR output (XOR of WORD_OUT) enabled by defining PACKER_PARITY_EN.
module fifo_bit_packer
  import packer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FIFO_DATA,
  input  logic             FIFO_EMPTY_N,
  output logic             FIFO_DEQ,
  input  logic             CLR,
  output logic [WIDTH-1:0] WORD_OUT,
  output logic             WORD_VALID,
  input  logic             WORD_READY,
`ifdef PACKER_PARITY_EN
  output logic             WORD_PAR,
`endif
  output logic [CNT_W-1:0] WORD_CNT
);

  pack_state_e      state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_word;
  logic             sr_last;
  logic             deq;
`ifdef PACKER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Gated by RST so no pop is requested while the block is held in reset.
  assign deq = RST & (state_q == FILL) & FIFO_EMPTY_N & ~CLR;

  packer_shift_reg #(.WIDTH(WIDTH)) u_sreg (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (deq),
    .clear    (CLR),
    .bit_in   (FIFO_DATA),
    .word     (sr_word),
    .last_bit (sr_last)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
`ifdef PACKER_PARITY_EN
    par_d   = par_q;
`endif
    if (CLR) begin
      // A word handed over in the CLR cycle is dropped and not counted.
      state_d = FILL;
      valid_d = 1'b0;
`ifdef PACKER_PARITY_EN
      par_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (deq && sr_last) begin
            word_d  = sr_word;
            valid_d = 1'b1;
            state_d = HOLD;
`ifdef PACKER_PARITY_EN
            par_d   = ^sr_word;
`endif
          end
        end
        HOLD: begin
          if (valid_q && WORD_READY) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= FILL;
      word_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
`ifdef PACKER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
`ifdef PACKER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign FIFO_DEQ   = deq;
  assign WORD_OUT   = word_q;
  assign WORD_VALID = valid_q;
  assign WORD_CNT   = cnt_q;
`ifdef PACKER_PARITY_EN
  assign WORD_PAR   = par_q;
`endif

endmodule
